// File: rtl/fp_unit_arbiter_if.sv
// Requester-side and unit-side signal bundle for fp_unit_arbiter.
// The arbiter takes the slave modport; requesters/unit model take the master modport.
interface fp_unit_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_start;
    logic [64*NUM_REQ-1:0] req_a;
    logic [64*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_busy;
    logic [NUM_REQ-1:0]    req_done;
    logic [63:0]           req_result;
    logic                  timeout_flag;
    logic [63:0]           unit_a;
    logic [63:0]           unit_b;
    logic                  unit_start;
    logic [63:0]           unit_c;
    logic                  unit_done;

    modport slave (
        input  req_start, req_a, req_b, unit_c, unit_done,
        output req_busy, req_done, req_result, timeout_flag,
        output unit_a, unit_b, unit_start
    );

    modport master (
        output req_start, req_a, req_b, unit_c, unit_done,
        input  req_busy, req_done, req_result, timeout_flag,
        input  unit_a, unit_b, unit_start
    );
endinterface

// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one start/done FP unit between NUM_REQ one-deep operand slots.
// Optional WAIT watchdog (quiet-NaN result + timeout_flag) enabled by defining FP_ARB_TIMEOUT_EN.
module fp_unit_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    fp_unit_arbiter_if.slave   bus
);
    localparam int          IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [63:0] QUIET_NAN = 64'h7FF8000000000000;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("fp_unit_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fp_unit_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   grant_reg, last_grant_reg;
    logic [IDX_W-1:0]   pick, cand;
    logic               pick_valid;
    int                 rr_sum;
    logic [NUM_REQ-1:0] pending_reg;
    logic [63:0]        slot_a_reg [NUM_REQ];
    logic [63:0]        slot_b_reg [NUM_REQ];
    logic [63:0]        unit_a_reg, unit_b_reg, result_reg;

`ifdef FP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             timed_out_reg;
    logic             timeout_hit;
`endif

    // First pending slot after last_grant, wrapping; last_grant itself is checked last.
    always_comb begin
        pick       = last_grant_reg;
        pick_valid = 1'b0;
        cand       = '0;
        rr_sum     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_sum = int'(last_grant_reg) + k;
            if (rr_sum >= NUM_REQ) begin
                rr_sum = rr_sum - NUM_REQ;
            end
            cand = IDX_W'(rr_sum);
            if (!pick_valid && pending_reg[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
`ifdef FP_ARB_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state_reg)
            IDLE:  if (pick_valid) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (bus.unit_done) begin
                    state_next = RESP;
                end
`ifdef FP_ARB_TIMEOUT_EN
                else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next  = RESP;
                    timeout_hit = 1'b1;
                end
`endif
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Slot capture is gated by the slot's own busy bit, so a slot is never
    // captured and released on the same edge.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pending_reg[gi] <= 1'b0;
                slot_a_reg[gi]  <= '0;
                slot_b_reg[gi]  <= '0;
            end else if (bus.req_start[gi] && !pending_reg[gi]) begin
                pending_reg[gi] <= 1'b1;
                slot_a_reg[gi]  <= bus.req_a[64*gi +: 64];
                slot_b_reg[gi]  <= bus.req_b[64*gi +: 64];
            end else if (state_reg == RESP && grant_reg == IDX_W'(gi)) begin
                pending_reg[gi] <= 1'b0;
            end
        end

        assign bus.req_done[gi] = (state_reg == RESP) && (grant_reg == IDX_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_reg      <= '0;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            unit_a_reg     <= '0;
            unit_b_reg     <= '0;
            result_reg     <= '0;
        end else begin
            if (state_reg == IDLE && pick_valid) begin
                grant_reg  <= pick;
                unit_a_reg <= slot_a_reg[pick];
                unit_b_reg <= slot_b_reg[pick];
            end
            if (state_reg == WAIT && bus.unit_done) begin
                result_reg <= bus.unit_c;
            end
`ifdef FP_ARB_TIMEOUT_EN
            else if (state_reg == WAIT && timeout_hit) begin
                result_reg <= QUIET_NAN;
            end
`endif
            if (state_reg == RESP) begin
                last_grant_reg <= grant_reg;
            end
        end
    end

`ifdef FP_ARB_TIMEOUT_EN
    // Counter restarts on the ISSUE->WAIT transition and runs only while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg  <= '0;
            timed_out_reg <= 1'b0;
        end else begin
            if (state_reg == ISSUE) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
            if (state_reg == WAIT && state_next == RESP) begin
                timed_out_reg <= timeout_hit;
            end
        end
    end

    assign bus.timeout_flag = (state_reg == RESP) && timed_out_reg;
`else
    assign bus.timeout_flag = 1'b0;
`endif

    assign bus.req_busy   = pending_reg;
    assign bus.req_result = result_reg;
    assign bus.unit_a     = unit_a_reg;
    assign bus.unit_b     = unit_b_reg;
    assign bus.unit_start = (state_reg == ISSUE);
endmodule

// File: doc/fp_unit_arbiter.md
Name: fp_unit_arbiter

Overview:
- Shares one two-operand, start/done floating-point unit (fp_adder, fp_mult or fp_divider) between NUM_REQ independent requesters, such as several fp_exp-style sequencers.
- Each requester owns a one-deep operand slot.
- Pending slots are granted round-robin, and the shared unit is driven with a one-cycle start.
- The result is returned with a per-requester one-cycle done pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit. Used only with FP_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- req_start  in  NUM_REQ  per-requester request pulse.
- req_a  in  64*NUM_REQ  operand A. Slot i occupies bits [64i+63:64i].
- req_b  in  64*NUM_REQ  operand B, same packing as req_a.
- req_busy  out  NUM_REQ  slot pending or in flight.
- req_done  out  NUM_REQ  one-cycle result-valid pulse, one-hot.
- req_result  out  64  shared result bus, valid while any req_done bit is high.
- timeout_flag  out  1  one-cycle pulse alongside req_done when the watchdog fired.
- unit_a  out  64  operand A to the shared unit.
- unit_b  out  64  operand B to the shared unit.
- unit_start  out  1  start pulse to the shared unit.
- unit_c  in  64  unit result.
- unit_done  in  1  unit completion pulse.

Behaviour:
- Reset values: req_busy=0, req_done=0, req_result=0, timeout_flag=0, unit_a=0, unit_b=0, unit_start=0, all slots cleared, state=IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority).
- Slot capture: on a clock edge with req_start[i]=1 and req_busy[i]=0, slot i latches req_a[i] and req_b[i], and req_busy[i] rises the next cycle. req_start[i] while req_busy[i]=1 is ignored; the operands are not overwritten.
- State machine IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
  - IDLE: if any slot is pending, grant the first pending index searching from last_grant+1 modulo NUM_REQ. Register unit_a and unit_b from that slot, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: unit_start=1 for exactly this cycle, then go to WAIT.
  - WAIT: on unit_done, register unit_c into req_result and go to RESP. unit_done in any other state is ignored.
  - RESP: req_done[grant]=1 for this cycle only. At the end of the cycle, clear slot grant, drop req_busy[grant] and set last_grant=grant. Go to IDLE.
- req_busy[grant] stays high through the RESP cycle. A req_start[grant] arriving in the RESP cycle is ignored.
- Latency: with the arbiter idle and req_start accepted at edge T, unit_start is high in cycle T+2. With unit_done in cycle T+2+k, req_done is high in cycle T+3+k.
- A new request from a slot that is not granted may arrive in any state. It waits for the next IDLE evaluation.
- Simultaneous req_start on several slots: all are captured in the same cycle. They are served in round-robin order starting from last_grant+1.
- unit_a and unit_b hold their values from IDLE until the next grant.
- req_result holds its last value after req_done falls.
- Reset mid-operation clears all pending slots and returns the FSM to IDLE. Any unit_done that arrives after reset, while the FSM is not in WAIT, is ignored.

Optional Feature:
- Macro FP_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES with no unit_done, req_result=64'h7FF8000000000000 (quiet NaN) and the FSM goes to RESP.
  - timeout_flag pulses with req_done.
  - The counter also clears on reset.
- Without the macro: no counter, timeout_flag is tied 0, and WAIT waits indefinitely.

Test Plan:
- Single request, adder unit. req_start[0] with a=64'h3FF0000000000000 (1.0), b=64'h4000000000000000 (2.0). Unit model answers in 3 cycles. Required: unit_start high for one cycle in cycle T+2; req_done[0] high in T+6 with req_result=64'h4008000000000000; req_busy[0] falls in T+7.
- All four slots requested in the same cycle with distinct operands. Required: grant order 0,1,2,3; exactly one req_done bit per result; each result matches its own slot's operands.
- Fairness. After slot 0 is served, slot 0 re-requests while slot 1 is pending. Required: slot 1 is served before slot 0.
- Busy ignore. Second req_start[2] with a different a while slot 2 is in flight. Required: result reflects the first operands; no extra req_done[2].
- rst_n asserted for 2 cycles while in WAIT with slots 1 and 3 pending. Required: all outputs return to reset values; a late unit_done produces no req_done; a subsequent request from slot 0 completes normally.
- FP_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and a unit that never responds. Required: req_done[0] and timeout_flag both high, req_result=64'h7FF8000000000000; the next request is served normally.
